usb_link_state: RTL and testbench
=================================

// Module: usb_link_state
// PURPOSE
//  Device-side USB bus-state controller. Sits between the PHY line decoder and the
//  protocol engine. Classifies bus conditions into bus reset, suspend and resume.
//  Sequences device-initiated remote wakeup and drives the reset/suspend strobes.
// PARAMETERS
//  RESET_CYC      120      consecutive SE0 cycles that qualify a bus reset (2.5us @48MHz)
//  SUSPEND_CYC    144000   consecutive J cycles that qualify suspend (3ms)
//  RWU_IDLE_CYC   240000   min cycles in SUSPEND before remote wakeup is honoured (5ms)
//  RWU_DRIVE_CYC  96000    cycles device drives K for remote wakeup (2ms)
//  CW             18       counter width; must hold every *_CYC value
// PORTS
//  clk            in   1  system clock
//  reset_i        in   1  system reset, asynchronous, active-high
//  line_state     in   2  synchronized bus state: 00 SE0, 01 J, 10 K, 11 SE1
//  remote_wakeup  in   1  level request from function to wake host
//  usb_reset_o    out  1  high while a qualified bus reset is in progress
//  suspend_o      out  1  high in SUSPEND
//  resume_o       out  1  high in RESUME (host- or device-initiated)
//  drive_k_o      out  1  PHY drives K (output enable + K) while high
//  state_o        out  3  0 ACTIVE, 1 BUS_RESET, 2 SUSPEND, 3 RWU_DRIVE, 4 RESUME
// BEHAVIOUR
//  - reset_i asserted: state=ACTIVE, all outputs 0, both counters 0; takes effect
//    immediately, including drive_k_o dropping mid-RWU_DRIVE.
//  - line_cnt: cycles line_state unchanged. Clears to 1 on change, else +1, saturates at 2^CW-1.
//  - state_cnt: cycles in current state. Clears to 0 on every transition, +1 otherwise, saturating.
//  - All outputs are registered and decoded from the next state, so they change in the
//    same cycle state_o changes.
//  - ACTIVE:
//      SE0 with line_cnt==RESET_CYC -> BUS_RESET.
//      J with line_cnt==SUSPEND_CYC -> SUSPEND.
//      K and SE1 are ignored.
//  - BUS_RESET:
//      usb_reset_o=1.
//      First cycle with line_state!=SE0 -> ACTIVE; usb_reset_o falls that cycle.
//  - SUSPEND: suspend_o=1. Priority order:
//      (1) SE0 with line_cnt==RESET_CYC -> BUS_RESET.
//      (2) K with line_cnt==2 (2-cycle glitch filter) -> RESUME.
//      (3) remote_wakeup=1 and state_cnt>=RWU_IDLE_CYC -> RWU_DRIVE.
//      Host K beats a simultaneous remote_wakeup.
//      remote_wakeup before RWU_IDLE_CYC is held off, not dropped, while still asserted.
//  - RWU_DRIVE:
//      drive_k_o=1 and resume_o=1; line_state is ignored.
//      state_cnt==RWU_DRIVE_CYC-1 -> RESUME, so drive_k_o is high for exactly RWU_DRIVE_CYC cycles.
//  - RESUME:
//      resume_o=1; host continues K.
//      Set an internal eop_seen flag on any SE0 cycle; the flag clears on entry to RESUME.
//      J while eop_seen -> ACTIVE.
//      SE0 with line_cnt==RESET_CYC -> BUS_RESET.
//  - SE1 is treated as "no change" in every state, except that it restarts line_cnt.
//  - usb_reset_o is ORed into nothing else; downstream must clear the device address on it.
// TESTING (bench params: RESET_CYC=8 SUSPEND_CYC=64 RWU_IDLE_CYC=100 RWU_DRIVE_CYC=32)
//  1 SE0 for 7 cycles then J -> no reset; SE0 for 20 cycles -> usb_reset_o rises on
//    cycle 8 of SE0, falls on first J cycle, state_o 0->1->0.
//  2 J for 64 cycles -> suspend_o=1 at cycle 64. Then K 1 cycle, J -> stays SUSPEND.
//    K 2 cycles -> resume_o=1. SE0 2 cycles then J -> state_o=0, resume_o=0.
//  3 In SUSPEND, remote_wakeup=1 at state_cnt=50 -> no action until state_cnt=100.
//    Then drive_k_o=1 for exactly 32 cycles, then RESUME with drive_k_o=0.
//  4 In SUSPEND, K (2nd cycle) coincides with RWU qualification -> RESUME, drive_k_o never asserted.
//  5 SE0 for 8 cycles during SUSPEND and during RESUME -> BUS_RESET with usb_reset_o=1
//    in both cases; suspend_o/resume_o=0.
//  6 reset_i pulsed mid-RWU_DRIVE (cycle 10) -> drive_k_o=0 asynchronously, state_o=0, counters 0.

Source files
------------

// File: rtl/usb_link_state_if.sv
// Bus-state signal bundle between the PHY line decoder / function and the
// USB link-state controller.
interface usb_link_state_if;
  logic [1:0] line_state;
  logic       remote_wakeup;
  logic       usb_reset_o;
  logic       suspend_o;
  logic       resume_o;
  logic       drive_k_o;
  logic [2:0] state_o;

  modport master (
    output line_state,
    output remote_wakeup,
    input  usb_reset_o,
    input  suspend_o,
    input  resume_o,
    input  drive_k_o,
    input  state_o
  );

  modport slave (
    input  line_state,
    input  remote_wakeup,
    output usb_reset_o,
    output suspend_o,
    output resume_o,
    output drive_k_o,
    output state_o
  );
endinterface

// File: rtl/usb_link_state.sv
// Device-side USB bus-state controller: qualifies bus reset, suspend and resume
// from the decoded line state and sequences device-initiated remote wakeup.
module usb_link_state #(
  parameter int RESET_CYC     = 120,
  parameter int SUSPEND_CYC   = 144000,
  parameter int RWU_IDLE_CYC  = 240000,
  parameter int RWU_DRIVE_CYC = 96000,
  parameter int CW            = 18
) (
  input  logic          clk,
  input  logic          reset_i,
  usb_link_state_if.slave bus
);

  typedef enum logic [2:0] {
    ST_ACTIVE    = 3'd0,
    ST_BUS_RESET = 3'd1,
    ST_SUSPEND   = 3'd2,
    ST_RWU_DRIVE = 3'd3,
    ST_RESUME    = 3'd4
  } state_t;

  localparam logic [1:0]    LS_SE0 = 2'b00;
  localparam logic [1:0]    LS_J   = 2'b01;
  localparam logic [1:0]    LS_K   = 2'b10;
  localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE       = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX       = {CW{1'b1}};
  localparam logic [CW-1:0] K_QUAL_CNT    = {{(CW-2){1'b0}}, 2'b10};
  localparam logic [CW-1:0] RESET_CNT     = CW'(RESET_CYC);
  localparam logic [CW-1:0] SUSPEND_CNT   = CW'(SUSPEND_CYC);
  localparam logic [CW-1:0] RWU_IDLE_CNT  = CW'(RWU_IDLE_CYC);
  localparam logic [CW-1:0] RWU_DRIVE_END = CW'(RWU_DRIVE_CYC - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [1:0]    line_prev_r;
  logic [CW-1:0] line_cnt_r;
  logic [CW-1:0] line_cnt_s;
  logic [CW-1:0] state_cnt_r;
  logic [CW-1:0] state_cnt_nxt_s;
  logic          eop_r;
  logic          eop_nxt_s;
  logic          usb_reset_r;
  logic          suspend_r;
  logic          resume_r;
  logic          drive_k_r;
  logic [2:0]    state_out_r;

  // Run length of the current line state, including this cycle (SE1 also restarts it).
  always_comb begin
    line_cnt_s = line_cnt_r;
    if (bus.line_state != line_prev_r) begin
      line_cnt_s = CNT_ONE;
    end else if (line_cnt_r == CNT_MAX) begin
      line_cnt_s = CNT_MAX;
    end else begin
      line_cnt_s = line_cnt_r + CNT_ONE;
    end
  end

  // Next-state decode; SE1 never matches a transition condition, so it holds state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACTIVE: begin
        if (bus.line_state == LS_SE0 && line_cnt_s == RESET_CNT) begin
          state_nxt_s = ST_BUS_RESET;
        end else if (bus.line_state == LS_J && line_cnt_s == SUSPEND_CNT) begin
          state_nxt_s = ST_SUSPEND;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_BUS_RESET: begin
        if (bus.line_state == LS_J || bus.line_state == LS_K) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_BUS_RESET;
        end
      end
      ST_SUSPEND: begin
        // Host reset, then host resume, then our own wakeup request.
        if (bus.line_state == LS_SE0 && line_cnt_s == RESET_CNT) begin
          state_nxt_s = ST_BUS_RESET;
        end else if (bus.line_state == LS_K && line_cnt_s == K_QUAL_CNT) begin
          state_nxt_s = ST_RESUME;
        end else if (bus.remote_wakeup && state_cnt_r >= RWU_IDLE_CNT) begin
          state_nxt_s = ST_RWU_DRIVE;
        end else begin
          state_nxt_s = ST_SUSPEND;
        end
      end
      ST_RWU_DRIVE: begin
        if (state_cnt_r == RWU_DRIVE_END) begin
          state_nxt_s = ST_RESUME;
        end else begin
          state_nxt_s = ST_RWU_DRIVE;
        end
      end
      ST_RESUME: begin
        if (bus.line_state == LS_SE0 && line_cnt_s == RESET_CNT) begin
          state_nxt_s = ST_BUS_RESET;
        end else if (bus.line_state == LS_J && eop_r) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_RESUME;
        end
      end
      default: begin
        state_nxt_s = ST_ACTIVE;
      end
    endcase
  end

  // Dwell counter and end-of-resume SE0 tracking.
  always_comb begin
    state_cnt_nxt_s = state_cnt_r;
    eop_nxt_s       = 1'b0;
    if (state_nxt_s != state_r) begin
      state_cnt_nxt_s = CNT_ZERO;
    end else if (state_cnt_r == CNT_MAX) begin
      state_cnt_nxt_s = CNT_MAX;
    end else begin
      state_cnt_nxt_s = state_cnt_r + CNT_ONE;
    end
    if (state_r == ST_RESUME && state_nxt_s == ST_RESUME) begin
      eop_nxt_s = eop_r | (bus.line_state == LS_SE0);
    end else begin
      eop_nxt_s = 1'b0;
    end
  end

  // State, counters and outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= ST_ACTIVE;
      line_prev_r <= LS_SE0;
      line_cnt_r  <= CNT_ZERO;
      state_cnt_r <= CNT_ZERO;
      eop_r       <= 1'b0;
      usb_reset_r <= 1'b0;
      suspend_r   <= 1'b0;
      resume_r    <= 1'b0;
      drive_k_r   <= 1'b0;
      state_out_r <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      line_prev_r <= bus.line_state;
      line_cnt_r  <= line_cnt_s;
      state_cnt_r <= state_cnt_nxt_s;
      eop_r       <= eop_nxt_s;
      usb_reset_r <= (state_nxt_s == ST_BUS_RESET);
      suspend_r   <= (state_nxt_s == ST_SUSPEND);
      resume_r    <= (state_nxt_s == ST_RESUME) || (state_nxt_s == ST_RWU_DRIVE);
      drive_k_r   <= (state_nxt_s == ST_RWU_DRIVE);
      state_out_r <= state_nxt_s;
    end
  end

  assign bus.usb_reset_o = usb_reset_r;
  assign bus.suspend_o   = suspend_r;
  assign bus.resume_o    = resume_r;
  assign bus.drive_k_o   = drive_k_r;
  assign bus.state_o     = state_out_r;

endmodule

// File: tb/tb_usb_link_state.sv
// Scoreboard bench for usb_link_state with shortened timing parameters.
module tb_usb_link_state;
  localparam logic [2:0] ST_ACT = 3'd0;
  localparam logic [2:0] ST_BR  = 3'd1;
  localparam logic [2:0] ST_SUS = 3'd2;
  localparam logic [2:0] ST_RWU = 3'd3;
  localparam logic [2:0] ST_RES = 3'd4;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  localparam logic [1:0] K   = 2'b10;
  localparam logic [1:0] SE1 = 2'b11;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];

  usb_link_state_if bus();

  usb_link_state #(
    .RESET_CYC(8), .SUSPEND_CYC(64), .RWU_IDLE_CYC(100), .RWU_DRIVE_CYC(32), .CW(18)
  ) dut (
    .clk(clk),
    .reset_i(reset_i),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // {state, usb_reset, suspend, resume, drive_k} required in each state
  function automatic logic [6:0] expv(input logic [2:0] st);
    case (st)
      ST_ACT:  return {3'd0, 4'b0000};
      ST_BR:   return {3'd1, 4'b1000};
      ST_SUS:  return {3'd2, 4'b0100};
      ST_RWU:  return {3'd3, 4'b0011};
      ST_RES:  return {3'd4, 4'b0010};
      default: return 7'h7f;
    endcase
  endfunction

  function automatic logic [6:0] obsv();
    return {bus.state_o, bus.usb_reset_o, bus.suspend_o, bus.resume_o, bus.drive_k_o};
  endfunction

  task automatic cyc(input logic [1:0] ls, input logic rwu, input logic [2:0] st);
    bus.line_state    = ls;
    bus.remote_wakeup = rwu;
    exp_q.push_back(expv(st));
    @(posedge clk);
    #1;
    obs_q.push_back(obsv());
  endtask

  task automatic enter_suspend();
    cyc(K, 1'b0, ST_ACT);
    for (int i = 0; i < 64; i++) cyc(J, 1'b0, (i < 63) ? ST_ACT : ST_SUS);
  endtask

  task automatic test_reset();
    bus.line_state = J;
    bus.remote_wakeup = 1'b0;
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obsv() !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obsv(), 7'd0);
    end
    checks++;
    if (dut.line_cnt_r !== 18'd0 || dut.state_cnt_r !== 18'd0) begin
      errors++;
      $display("FAIL reset_counters: got line=%0d state=%0d expected 0 0", dut.line_cnt_r, dut.state_cnt_r);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_bus_reset();
    logic [6:0] e, o;
    int n = 0;
    repeat (3) cyc(J, 1'b0, ST_ACT);
    repeat (7) cyc(SE0, 1'b0, ST_ACT);
    cyc(J, 1'b0, ST_ACT);
    repeat (5) cyc(SE0, 1'b0, ST_ACT);
    cyc(SE1, 1'b0, ST_ACT);
    repeat (5) cyc(SE0, 1'b0, ST_ACT);
    cyc(J, 1'b0, ST_ACT);
    for (int i = 0; i < 20; i++) cyc(SE0, 1'b0, (i < 7) ? ST_ACT : ST_BR);
    cyc(J, 1'b0, ST_ACT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL bus_reset step %0d: got %b expected %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_suspend_resume();
    logic [6:0] e, o;
    int n = 0;
    enter_suspend();
    cyc(K, 1'b0, ST_SUS);
    cyc(J, 1'b0, ST_SUS);
    cyc(K, 1'b0, ST_SUS);
    cyc(K, 1'b0, ST_RES);
    repeat (2) cyc(K, 1'b0, ST_RES);
    repeat (2) cyc(SE0, 1'b0, ST_RES);
    cyc(J, 1'b0, ST_ACT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL suspend_resume step %0d: got %b expected %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_remote_wakeup();
    logic [6:0] e, o;
    int n = 0;
    enter_suspend();
    for (int k = 0; k <= 100; k++) cyc(J, (k >= 50), (k < 100) ? ST_SUS : ST_RWU);
    for (int j = 0; j < 32; j++) cyc(J, 1'b1, (j < 31) ? ST_RWU : ST_RES);
    repeat (2) cyc(K, 1'b0, ST_RES);
    cyc(SE0, 1'b0, ST_RES);
    cyc(J, 1'b0, ST_ACT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL remote_wakeup step %0d: got %b expected %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_k_beats_rwu();
    logic [6:0] e, o;
    int n = 0;
    enter_suspend();
    for (int k = 0; k < 99; k++) cyc(J, 1'b1, ST_SUS);
    cyc(K, 1'b1, ST_SUS);
    cyc(K, 1'b1, ST_RES);
    cyc(SE0, 1'b0, ST_RES);
    cyc(J, 1'b0, ST_ACT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL k_beats_rwu step %0d: got %b expected %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_reset_from_low_power();
    logic [6:0] e, o;
    int n = 0;
    enter_suspend();
    for (int i = 0; i < 8; i++) cyc(SE0, 1'b0, (i < 7) ? ST_SUS : ST_BR);
    cyc(J, 1'b0, ST_ACT);
    enter_suspend();
    cyc(K, 1'b0, ST_SUS);
    cyc(K, 1'b0, ST_RES);
    for (int i = 0; i < 8; i++) cyc(SE0, 1'b0, (i < 7) ? ST_RES : ST_BR);
    cyc(J, 1'b0, ST_ACT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_from_low_power step %0d: got %b expected %b", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] e, o;
    int n = 0;
    enter_suspend();
    for (int k = 0; k <= 100; k++) cyc(J, 1'b1, (k < 100) ? ST_SUS : ST_RWU);
    for (int j = 0; j < 9; j++) cyc(J, 1'b1, ST_RWU);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_reset_setup step %0d: got %b expected %b", n, o, e);
      end
      n++;
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (obsv() !== 7'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %b expected %b", obsv(), 7'd0);
    end
    checks++;
    if (dut.line_cnt_r !== 18'd0 || dut.state_cnt_r !== 18'd0) begin
      errors++;
      $display("FAIL async_reset_counters: got line=%0d state=%0d expected 0 0", dut.line_cnt_r, dut.state_cnt_r);
    end
    bus.remote_wakeup = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    cyc(J, 1'b0, ST_ACT);
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL async_reset_release: got %b expected %b", o, e);
    end
  endtask

  initial begin
    bus.line_state = J;
    bus.remote_wakeup = 1'b0;
    test_reset();
    test_bus_reset();
    test_suspend_resume();
    test_remote_wakeup();
    test_k_beats_rwu();
    test_reset_from_low_power();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
